receiver_demux: RTL and testbench

//   Receive-side counterpart of the transmitter's 2:1 serial mux. Takes the single serialized
//   bit stream and de-multiplexes each frame into INFO_LEN info bits, then PAR_LEN parity bits.

---
 rtl/receiver_demux_pkg.sv | 19 +
 rtl/receiver_demux_rx_shift_reg.sv | 21 ++
 rtl/receiver_demux.sv | 122 ++++++++++++
 tb/tb_receiver_demux.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/receiver_demux_pkg.sv
// Shared definitions for the receive-side serial demux: frame defaults, FSM states,
// and the bit-counter width helper.
package rce_pkg;

  localparam int INFO_LEN_DEF = 16;
  localparam int PAR_LEN_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Counter must reach the full frame length without wrapping.
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/receiver_demux_rx_shift_reg.sv
// MSB-first serial-to-parallel shift register. The first bit shifted in ends up at the MSB
// after W enabled cycles.
module rx_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/receiver_demux.sv
// Splits a serial frame (info bits, then parity bits) into a parallel word pair on a
// valid/ready output. Optional framing-error detection: RECEIVER_DEMUX_SYNC_ERR_EN.
//
//   state | meaning
//   IDLE  | waiting for a beat with frame_start; other beats are dropped
//   RECV  | assembling a frame, cnt = bits already taken
//   HOLD  | frame complete but output register occupied; input stalled
module receiver_demux
  import rce_pkg::*;
#(
  parameter int INFO_LEN = INFO_LEN_DEF,
  parameter int PAR_LEN  = PAR_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_valid,
  input  logic                frame_start,
  output logic                din_ready,
  output logic [INFO_LEN-1:0] info_word,
  output logic [PAR_LEN-1:0]  par_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sync_err
);

  localparam int CW = cnt_width(INFO_LEN + PAR_LEN);
  localparam logic [CW-1:0] INFO_C = CW'(INFO_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(INFO_LEN + PAR_LEN - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [INFO_LEN-1:0] info_q;
  logic [PAR_LEN-1:0]  par_q;
  logic                beat;
  logic                frame_err;
  logic                info_en;
  logic                par_en;

  assign din_ready = (state != HOLD);
  assign beat      = din_valid && din_ready;

`ifdef RECEIVER_DEMUX_SYNC_ERR_EN
  assign frame_err = beat && (state == RECV) && frame_start;
`else
  assign frame_err = 1'b0;
`endif

  // A resync bit restarts the info field, so it always goes to the info register.
  assign info_en = beat && ((state == IDLE && frame_start) || frame_err ||
                            (state == RECV && cnt < INFO_C));
  assign par_en  = beat && (state == RECV) && !frame_err && (cnt >= INFO_C);

  rx_shift_reg #(.W(INFO_LEN)) u_info (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (info_en),
    .din   (din),
    .q     (info_q)
  );

  rx_shift_reg #(.W(PAR_LEN)) u_par (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (par_en),
    .din   (din),
    .q     (par_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      info_word <= '0;
      par_word  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (beat && frame_start) begin
            state <= RECV;
            cnt   <= CW'(1);
          end
        end
        RECV: begin
          if (beat) begin
            if (frame_err) begin
              cnt      <= CW'(1);
              sync_err <= 1'b1;
            end else if (cnt == LAST_C) begin
              cnt <= '0;
              // Last parity bit is still on din; bypass it into the output load.
              if (!out_valid || out_ready) begin
                info_word <= info_q;
                par_word  <= {par_q[PAR_LEN-2:0], din};
                out_valid <= 1'b1;
                state     <= IDLE;
              end else begin
                state <= HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            info_word <= info_q;
            par_word  <= par_q;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver_demux.sv
// Directed bench for receiver_demux: clean frames, back-to-back, backpressure, gaps,
// mid-frame frame_start, and asynchronous reset.
module tb_receiver_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        frame_start;
  logic        din_ready;
  logic [15:0] info_word;
  logic [15:0] par_word;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int syncs  = 0;
  int stalls = 0;
  bit gaps   = 1'b0;
  logic [15:0] last_info;
  logic [15:0] last_par;
  logic [15:0] held_info;

  receiver_demux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .din_ready   (din_ready),
    .info_word   (info_word),
    .par_word    (par_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      last_info = info_word;
      last_par  = par_word;
    end
    if (sync_err) syncs++;
    if (!din_ready) stalls++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!din_ready && k < 200) begin
      tick();
      k++;
    end
    if (!din_ready) chk("din_ready_timeout", 32'd0, 32'd1);
  endtask

  // Bits go out MSB first: frame = {info, par}.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 40) begin
          din_valid = 1'b0;
          tick();
        end
      end
      din         = bits[31-i];
      frame_start = (i == 0);
      din_valid   = 1'b1;
      wait_ready();
      tick();
    end
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    chk("rst_info",      32'(info_word), 32'd0);
    chk("rst_par",       32'(par_word),  32'd0);
    chk("rst_sync_err",  32'(sync_err),  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: single clean frame, out_valid right after the last beat, for one cycle.
    out_ready = 1'b1;
    send_bits({16'hA5C3, 16'h0F0F}, 32);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_info",  32'(info_word), 32'h0000A5C3);
    chk("t1_par",   32'(par_word),  32'h00000F0F);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // 2: back-to-back frames with no bubble.
    stalls = 0;
    send_bits({16'h1234, 16'hFFFF}, 32);
    chk("t2_valid1", 32'(out_valid), 32'd1);
    chk("t2_info1",  32'(info_word), 32'h00001234);
    chk("t2_par1",   32'(par_word),  32'h0000FFFF);
    send_bits({16'h8001, 16'h0000}, 32);
    chk("t2_valid2", 32'(out_valid), 32'd1);
    chk("t2_info2",  32'(info_word), 32'h00008001);
    chk("t2_par2",   32'(par_word),  32'h00000000);
    chk("t2_no_stall", 32'(stalls),  32'd0);
    tick();

    // 3: backpressure across two frames.
    out_ready = 1'b0;
    send_bits({16'h1111, 16'h2222}, 32);
    chk("t3_valid1", 32'(out_valid), 32'd1);
    held_info = info_word;
    send_bits({16'h3333, 16'h4444}, 32);
    repeat (5) tick();
    chk("t3_hold_info",  32'(info_word), 32'h00001111);
    chk("t3_hold_par",   32'(par_word),  32'h00002222);
    chk("t3_hold_stable", 32'(info_word), 32'(held_info));
    chk("t3_hold_ready", 32'(din_ready), 32'd0);
    xfers = 0;
    out_ready = 1'b1;
    tick();
    chk("t3_first_info", 32'(last_info), 32'h00001111);
    chk("t3_valid2",     32'(out_valid), 32'd1);
    chk("t3_info2",      32'(info_word), 32'h00003333);
    chk("t3_par2",       32'(par_word),  32'h00004444);
    chk("t3_ready_back", 32'(din_ready), 32'd1);
    tick();
    chk("t3_xfers",      32'(xfers),     32'd2);
    chk("t3_valid_drop", 32'(out_valid), 32'd0);

    // 4: random idle gaps.
    gaps = 1'b1;
    send_bits({16'hDEAD, 16'hBEEF}, 32);
    gaps = 1'b0;
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_info",  32'(info_word), 32'h0000DEAD);
    chk("t4_par",   32'(par_word),  32'h0000BEEF);
    tick();

    // 5: frame_start at bit 10 of a partial frame.
    xfers = 0;
    syncs = 0;
    send_bits({16'hAAAA, 16'h5555}, 10);
    send_bits({16'h00FF, 16'hFF00}, 32);
    repeat (3) tick();
    chk("t5_xfers", 32'(xfers), 32'd1);
`ifdef RECEIVER_DEMUX_SYNC_ERR_EN
    chk("t5_syncs", 32'(syncs),     32'd1);
    chk("t5_info",  32'(last_info), 32'h000000FF);
    chk("t5_par",   32'(last_par),  32'h0000FF00);
`else
    chk("t5_syncs", 32'(syncs),     32'd0);
    chk("t5_info",  32'(last_info), 32'h0000AA80);
    chk("t5_par",   32'(last_par),  32'h00003FFF);
`endif

    // 6: asynchronous reset mid-frame while a pair is pending.
    out_ready = 1'b0;
    send_bits({16'h0001, 16'h0002}, 32);
    send_bits({16'hFFFF, 16'hFFFF}, 20);
    chk("t6_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_info",  32'(info_word), 32'd0);
    chk("t6_rst_par",   32'(par_word),  32'd0);
    chk("t6_rst_ready", 32'(din_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_bits({16'h5A5A, 16'hC3C3}, 32);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_info",  32'(info_word), 32'h00005A5A);
    chk("t6_par",   32'(par_word),  32'h0000C3C3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
